// File: rtl/dsp_reset_sequencer_if.sv
// Bus-master lines shared between the DSP reset sequencer and the I/O ports
// it addresses. The master drives address/data/direction, the slave side
// returns the read data.
interface dsp_reset_sequencer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic [15:0]           address;
    logic                  data_dir;

    modport master (
        input  data_in,
        output data_out,
        output address,
        output data_dir
    );

    modport slave (
        output data_in,
        input  data_out,
        input  address,
        input  data_dir
    );
endinterface

// File: rtl/dsp_reset_sequencer.sv
// DSP reset handshake: pulse the reset port, poll status/data ports for the
// 0xAA acknowledge with a bounded wait, retry a limited number of times and
// report DONE or FAIL. All outputs are Moore-decoded and tri-stated by enable.
module dsp_reset_sequencer #(
    parameter logic [15:0] BASE_ADDRESS = 16'h0220,
    parameter int          DATA_WIDTH   = 16,
    parameter int          PULSE_CYCLES = 24,
    parameter int          POLL_TIMEOUT = 1024,
    parameter int          MAX_RETRIES  = 3,
    parameter bit          AUTO_START   = 1'b1
) (
    input  logic                  bus_clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  start,
    dsp_reset_sequencer_if.master bus,
    output logic                  accepted,
    output logic                  failed,
    output logic                  busy,
    output logic [3:0]            retry_count
);

    localparam int PULSE_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int TMO_W   = (POLL_TIMEOUT > 1) ? $clog2(POLL_TIMEOUT) : 1;

    localparam logic [PULSE_W-1:0]    PULSE_LAST  = PULSE_W'(PULSE_CYCLES - 1);
    localparam logic [TMO_W-1:0]      TMO_LAST    = TMO_W'(POLL_TIMEOUT - 1);
    localparam logic [3:0]            RETRY_LIMIT = 4'(MAX_RETRIES);
    localparam logic [DATA_WIDTH-1:0] ACK_VALUE   = DATA_WIDTH'('hAA);

    localparam logic [15:0] ADDR_RESET  = BASE_ADDRESS + 16'h0006;
    localparam logic [15:0] ADDR_DATA   = BASE_ADDRESS + 16'h000A;
    localparam logic [15:0] ADDR_STATUS = BASE_ADDRESS + 16'h000E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE_1,
        ST_WAIT,
        ST_WRITE_0,
        ST_POLL_STATUS,
        ST_READ_DATA,
        ST_DONE,
        ST_FAIL
    } state_e;

    localparam state_e RESET_STATE = AUTO_START ? ST_WRITE_1 : ST_IDLE;

    state_e             state_q, state_d;
    logic [PULSE_W-1:0] pulse_q, pulse_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [3:0]         retry_q, retry_d;

    logic                  timeout;
    logic                  tmo_last;
    logic [DATA_WIDTH-1:0] dout_c;
    logic [15:0]           addr_c;
    logic                  dir_c;
    logic                  accepted_c;
    logic                  failed_c;
    logic                  busy_c;

    assign tmo_last = (tmo_q == TMO_LAST);

    // State and counter registers.
    always_ff @(posedge bus_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RESET_STATE;
            pulse_q <= '0;
            tmo_q   <= '0;
            retry_q <= '0;
        end else begin
            // NOTE: every register here uses <= so all of them update from
            // the same pre-edge values, independent of statement order.
            state_q <= state_d;
            pulse_q <= pulse_d;
            tmo_q   <= tmo_d;
            retry_q <= retry_d;
        end
    end

    // Next-state, counter and retry decisions.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        pulse_d = pulse_q;
        tmo_d   = tmo_q;
        retry_d = retry_q;
        timeout = 1'b0;

        // The poll counter saturates at its last value, so a status hit on
        // the final poll cycle still gets exactly one data read.
        if (state_q == ST_POLL_STATUS || state_q == ST_READ_DATA) begin
            tmo_d = tmo_last ? tmo_q : tmo_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WRITE_1;
                    retry_d = '0;
                end
            end
            ST_WRITE_1: begin
                state_d = ST_WAIT;
                pulse_d = '0;
            end
            ST_WAIT: begin
                if (pulse_q == PULSE_LAST) state_d = ST_WRITE_0;
                else                       pulse_d = pulse_q + 1'b1;
            end
            ST_WRITE_0: begin
                state_d = ST_POLL_STATUS;
                tmo_d   = '0;
            end
            ST_POLL_STATUS: begin
                if (bus.data_in[7]) state_d = ST_READ_DATA;
                else                timeout = tmo_last;
            end
            ST_READ_DATA: begin
                if (bus.data_in == ACK_VALUE) state_d = ST_DONE;
                else                          timeout = tmo_last;
            end
            ST_DONE, ST_FAIL: begin
                if (start) begin
                    state_d = ST_WRITE_1;
                    retry_d = '0;
                end
            end
        endcase

        if (timeout) begin
            if (retry_q < RETRY_LIMIT) begin
                retry_d = retry_q + 1'b1;
                state_d = ST_WRITE_1;
            end else begin
                state_d = ST_FAIL;
            end
        end
    end

    // Moore output decode from the current state.
    always_comb begin
        dout_c     = '0;
        addr_c     = ADDR_RESET;
        dir_c      = 1'b1;
        accepted_c = 1'b0;
        failed_c   = 1'b0;
        busy_c     = 1'b0;
        case (state_q)
            ST_IDLE:        addr_c = '0;
            ST_WRITE_1: begin
                dout_c = DATA_WIDTH'(1);
                busy_c = 1'b1;
            end
            ST_WAIT:        busy_c = 1'b1;
            ST_WRITE_0:     busy_c = 1'b1;
            ST_POLL_STATUS: begin
                addr_c = ADDR_STATUS;
                dir_c  = 1'b0;
                busy_c = 1'b1;
            end
            ST_READ_DATA: begin
                addr_c = ADDR_DATA;
                dir_c  = 1'b0;
                busy_c = 1'b1;
            end
            ST_DONE: begin
                addr_c     = ADDR_STATUS;
                dir_c      = 1'b0;
                accepted_c = 1'b1;
            end
            ST_FAIL:        failed_c = 1'b1;
        endcase
    end

    // Release every output when the block is not enabled; the sequence itself
    // keeps running underneath.
    assign bus.data_out = enable ? dout_c     : {DATA_WIDTH{1'bz}};
    assign bus.address  = enable ? addr_c     : 16'bz;
    assign bus.data_dir = enable ? dir_c      : 1'bz;
    assign accepted     = enable ? accepted_c : 1'bz;
    assign failed       = enable ? failed_c   : 1'bz;
    assign busy         = enable ? busy_c     : 1'bz;
    assign retry_count  = enable ? retry_q    : 4'bz;

endmodule

// File: tb/tb_dsp_reset_sequencer.sv
// Bench for dsp_reset_sequencer. A timeline model (cycle offset within the
// current attempt, poll window index, attempt count) predicts every output;
// each scenario task drives stimulus and compares the full output set per cycle.
module tb_dsp_reset_sequencer;

    localparam int          P    = 24;
    localparam int          T    = 16;
    localparam int          R    = 2;
    localparam logic [15:0] BASE = 16'h0220;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] dout;
        logic        dir;
        logic        acc;
        logic        fail;
        logic        busy;
        logic [3:0]  retry;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       start = 1'b0;
    logic       accepted;
    logic       failed;
    logic       busy;
    logic [3:0] retry_count;

    int checks = 0;
    int errors = 0;

    // Model: fin 0 = attempt running, 1 = done, 2 = failed.
    int          cyc = 0;
    int          att_start = 0;
    int          retries = 0;
    int          fin = 0;
    bit          in_data = 1'b0;
    logic [15:0] cur_d = '0;
    bit          cur_st = 1'b0;

    always #5 clk = ~clk;

    dsp_reset_sequencer_if #(.DATA_WIDTH(16)) bus ();

    dsp_reset_sequencer #(
        .BASE_ADDRESS(BASE),
        .DATA_WIDTH  (16),
        .PULSE_CYCLES(P),
        .POLL_TIMEOUT(T),
        .MAX_RETRIES (R),
        .AUTO_START  (1'b1)
    ) dut (
        .bus_clock  (clk),
        .reset_n    (rst_n),
        .enable     (enable),
        .start      (start),
        .bus        (bus),
        .accepted   (accepted),
        .failed     (failed),
        .busy       (busy),
        .retry_count(retry_count)
    );

    function automatic obs_t sample();
        return {bus.address, bus.data_out, bus.data_dir, accepted, failed, busy, retry_count};
    endfunction

    function automatic int window();
        return cyc - att_start - (P + 2);
    endfunction

    // Expected outputs for the current cycle from the attempt timeline.
    function automatic obs_t expect_now();
        obs_t e;
        int   off;
        if (!enable) begin
            e = 'z;
            return e;
        end
        e = '0;
        e.retry = 4'(retries);
        if (fin == 1) begin
            e.addr = BASE + 16'hE;
            e.acc  = 1'b1;
        end else if (fin == 2) begin
            e.addr = BASE + 16'h6;
            e.dir  = 1'b1;
            e.fail = 1'b1;
        end else begin
            off    = cyc - att_start;
            e.busy = 1'b1;
            if (off <= P + 1) begin
                e.addr = BASE + 16'h6;
                e.dir  = 1'b1;
                e.dout = (off == 0) ? 16'd1 : 16'd0;
            end else begin
                e.addr = in_data ? BASE + 16'hA : BASE + 16'hE;
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        fin       = 0;
        retries   = 0;
        in_data   = 1'b0;
        att_start = cyc;
    endtask

    // Advance the model by one clock using the inputs held this cycle.
    task automatic model_step();
        int w;
        bit ok;
        w = window();
        if (fin == 0 && w >= 0) begin
            ok = in_data ? (cur_d == 16'h00AA) : cur_d[7];
            if (ok) begin
                if (in_data) fin = 1;
                else         in_data = 1'b1;
            end else if (w >= T - 1) begin
                if (retries < R) begin
                    retries++;
                    att_start = cyc + 1;
                    in_data   = 1'b0;
                end else begin
                    fin = 2;
                end
            end
        end else if (fin != 0 && cur_st) begin
            fin       = 0;
            retries   = 0;
            in_data   = 1'b0;
            att_start = cyc + 1;
        end
        cyc++;
    endtask

    // Drive inputs just after a rising edge, then move to the sampling point.
    task automatic apply(input logic [15:0] d, input bit st);
        bus.data_in = d;
        start       = st;
        cur_d       = d;
        cur_st      = st;
        @(negedge clk);
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] non_ack();
        logic [15:0] r;
        r = 16'($urandom);
        if (r == 16'h00AA) r = 16'h0055;
        return r;
    endfunction

    function automatic logic [15:0] nominal_data(input int c);
        if (c == 30)           return 16'h0080;
        if (c == 33)           return 16'h00AA;
        if (c > 30 && c < 33)  return non_ack();
        return 16'($urandom) & 16'hFF7F;
    endfunction

    task automatic test_reset();
        obs_t got;
        obs_t exp;
        rst_n = 1'b0;
        enable = 1'b1;
        bus.data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        got = sample();
        exp = expect_now();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", got, exp);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_nominal();
        obs_t got;
        obs_t exp;
        for (int c = 0; c < 40; c++) begin
            apply(nominal_data(c), 1'b0);
            got = sample();
            exp = expect_now();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL nominal c=%0d got=%h want=%h", c, got, exp);
            end
            advance();
        end
    endtask

    task automatic test_timeout_retry();
        obs_t got;
        obs_t exp;
        int   n = 0;
        int   tail = 0;
        bit   st;
        while (tail < 6 && n < 300) begin
            st = (n == 0) ? 1'b1 : (fin == 0 && $urandom_range(0, 7) == 0);
            apply(16'($urandom) & 16'hFF7F, st);
            got = sample();
            exp = expect_now();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL timeout_retry n=%0d got=%h want=%h", n, got, exp);
            end
            advance();
            if (fin == 2) tail++;
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL timeout_retry_budget got=%0d want<300", n);
        end
    endtask

    task automatic test_wrong_ack();
        obs_t        got;
        obs_t        exp;
        logic [15:0] d;
        int          n = 0;
        int          tail = 0;
        int          w;
        while (tail < 4 && n < 200) begin
            w = window();
            if (fin != 0 || w < 0)  d = non_ack();
            else if (retries == 0)  d = in_data ? non_ack() : ((w == 2) ? 16'h0080 : 16'h0000);
            else if (!in_data)      d = 16'h0080;
            else                    d = (w == T - 1) ? 16'h00AA : 16'h0055;
            apply(d, n == 0);
            got = sample();
            exp = expect_now();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL wrong_ack n=%0d got=%h want=%h", n, got, exp);
            end
            advance();
            if (fin == 1) tail++;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL wrong_ack_budget got=%0d want<200", n);
        end
    endtask

    task automatic test_reset_mid_wait();
        obs_t got;
        obs_t exp;
        int   off;
        bit   did_reset = 1'b0;
        for (int i = 0; i < 60; i++) begin
            off = cyc - att_start;
            if (!did_reset && fin == 0 && off == 10) begin
                did_reset = 1'b1;
                rst_n = 1'b0;
                #1;
                model_reset();
                got = sample();
                exp = expect_now();
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL reset_mid_wait_async got=%h want=%h", got, exp);
                end
                @(posedge clk);
                #1;
                cyc++;
                rst_n = 1'b1;
                model_reset();
                off = 0;
            end
            apply(16'h0000, (i == 0) || (fin == 0 && off == 5));
            got = sample();
            exp = expect_now();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_mid_wait i=%0d got=%h want=%h", i, got, exp);
            end
            advance();
        end
    endtask

    task automatic test_enable();
        obs_t got;
        obs_t exp;
        enable = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 44; c++) begin
            if (c == 40) enable = 1'b1;
            apply(nominal_data(c), 1'b0);
            got = sample();
            exp = expect_now();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL enable c=%0d en=%0b got=%h want=%h", c, enable, got, exp);
            end
            advance();
        end
    endtask

    task automatic test_random();
        obs_t        got;
        obs_t        exp;
        logic [15:0] d;
        int          sel;
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 7);
            if (sel < 2)      d = 16'h00AA;
            else if (sel < 4) d = 16'h0080 | 16'($urandom);
            else              d = 16'($urandom) & 16'hFF7F;
            enable = ($urandom_range(0, 3) != 0);
            apply(d, $urandom_range(0, 15) == 0);
            got = sample();
            exp = expect_now();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random i=%0d got=%h want=%h", i, got, exp);
            end
            advance();
        end
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout_retry();
        test_wrong_ack();
        test_reset_mid_wait();
        test_enable();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
